// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-result streaming path: default sizes and
// the streamer FSM state encoding.
package mat_pkg;

  localparam int MATSIZE_DEFAULT = 16;
  localparam int DATA_W_DEFAULT  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/stream_fifo.sv
// Small power-of-two FIFO with a registered head word; the head is presented
// directly as the AXI-Stream data of the streamer.
module stream_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: the storage is reset too, so the exposed head word is a known 0
  // out of reset; this is only reasonable because the array is a few words deep.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mat_result_streamer.sv
// Reads a finished result frame out of the result BRAM in address order and
// streams it as AXI-Stream beats, with credit-based read issue into a FIFO.
module mat_result_streamer
  import mat_pkg::*;
#(
  parameter  int MATSIZE    = MATSIZE_DEFAULT,
  parameter  int DATA_W     = DATA_W_DEFAULT,
  parameter  int RD_LAT     = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int FRAME_LEN  = MATSIZE * MATSIZE,
  localparam int ADDR_W     = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              start_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);

  localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              credit_ok;
  logic              handshake;

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (vld_q[RD_LAT-1]),
    .data_i  (rd_data),
    .pop_i   (handshake),
    .data_o  (m_tdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m_tvalid  = ~fifo_empty;
  assign m_tlast   = m_tvalid & (beat_q == LAST_IDX);
  assign handshake = m_tvalid & m_tready;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign start_err = err_q;
  assign rd_addr   = addr_q;

  // Reads still travelling through the BRAM pipeline already own a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vld_q[i]);
    occupancy = {1'b0, fifo_count} + {1'b0, inflight};
    credit_ok = (occupancy < (CNT_W + 1)'(FIFO_DEPTH)) & ~fifo_full;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    err_d   = err_q;
    done_d  = 1'b0;
    rd_en   = 1'b0;

    if (handshake) beat_d = (beat_q == LAST_IDX) ? '0 : beat_q + ADDR_W'(1);
    if (start && (state_q != IDLE)) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          addr_d  = '0;
          beat_d  = '0;
        end
      end
      STREAM: begin
        if (credit_ok) begin
          rd_en  = 1'b1;
          addr_d = (addr_q == LAST_IDX) ? '0 : addr_q + ADDR_W'(1);
          if (addr_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (handshake && m_tlast) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    vld_d[0] = rd_en;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
    end
  end

endmodule
